// File: rtl/obi_apb_bridge_n.sv
// OBI-to-APB splitter: decodes NUM_TARGETS equal slots above ADDR_BASE onto
// per-target APB ports, with a slot enable mask, decode errors and a PREADY timeout.
module obi_apb_bridge_n #(
  parameter int unsigned       NUM_TARGETS    = 4,
  parameter int unsigned       OBI_AW         = 32,
  parameter int unsigned       OBI_DW         = 32,
  parameter int unsigned       OBI_IDW        = 1,
  parameter logic [OBI_AW-1:0] ADDR_BASE      = 32'h0103_0000,
  parameter int unsigned       SS_SIZE        = 'h100,
  parameter int unsigned       TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          obi_req,
  output logic                          obi_gnt,
  input  logic [OBI_AW-1:0]             obi_addr,
  input  logic                          obi_we,
  input  logic [OBI_DW/8-1:0]           obi_be,
  input  logic [OBI_DW-1:0]             obi_wdata,
  input  logic [OBI_IDW-1:0]            obi_aid,
  output logic                          obi_rvalid,
  input  logic                          obi_rready,
  output logic [OBI_DW-1:0]             obi_rdata,
  output logic [OBI_IDW-1:0]            obi_rid,
  output logic                          obi_err,
  input  logic [NUM_TARGETS-1:0]        ss_ctrl_icn,
  output logic                          err_pulse,
  output logic [NUM_TARGETS-1:0]        APB_PSEL,
  output logic [NUM_TARGETS-1:0]        APB_PENABLE,
  output logic [OBI_AW-1:0]             APB_PADDR,
  output logic                          APB_PWRITE,
  output logic [OBI_DW-1:0]             APB_PWDATA,
  output logic [OBI_DW/8-1:0]           APB_PSTRB,
  input  logic [NUM_TARGETS*OBI_DW-1:0] APB_PRDATA,
  input  logic [NUM_TARGETS-1:0]        APB_PREADY,
  input  logic [NUM_TARGETS-1:0]        APB_PSLVERR
);

  localparam int unsigned BW     = OBI_DW / 8;
  localparam int unsigned IW     = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int unsigned NP     = 1 << IW;
  localparam int unsigned SS_LOG = $clog2(SS_SIZE);
  localparam int unsigned CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [OBI_AW:0] WIN_SIZE = (OBI_AW + 1)'(NUM_TARGETS * SS_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e                 r_state;
  logic [IW-1:0]          r_idx;
  logic [CW-1:0]          r_cnt;
  logic [NUM_TARGETS-1:0] r_psel;
  logic [NUM_TARGETS-1:0] r_penable;
  logic [OBI_AW-1:0]      r_paddr;
  logic                   r_pwrite;
  logic [OBI_DW-1:0]      r_pwdata;
  logic [BW-1:0]          r_pstrb;
  logic                   r_rvalid;
  logic                   r_err;
  logic                   r_err_pulse;
  logic [OBI_DW-1:0]      r_rdata;
  logic [OBI_IDW-1:0]     r_rid;

  logic [OBI_AW-1:0]      w_off;
  logic [IW-1:0]          w_idx;
  logic [NP-1:0]          w_en_pad;
  logic [NP-1:0]          w_rdy_pad;
  logic [NP-1:0]          w_slverr_pad;
  logic                   w_in_win;
  logic                   w_hit;
  logic [NUM_TARGETS-1:0] w_onehot;
  logic                   w_ready;
  logic                   w_slverr;
  logic [OBI_DW-1:0]      w_prdata;
  logic [CW-1:0]          w_cnt_inc;
  logic                   w_timeout;

  // Unsigned offset wraps for addresses below the base; the explicit >= rejects those.
  assign w_off    = obi_addr - ADDR_BASE;
  assign w_idx    = w_off[SS_LOG +: IW];
  assign w_in_win = (obi_addr >= ADDR_BASE) && ({1'b0, w_off} < WIN_SIZE);
  assign w_en_pad = NP'(ss_ctrl_icn);
  assign w_hit    = w_in_win && w_en_pad[w_idx];
  assign w_onehot = NUM_TARGETS'(1) << w_idx;

  // Only the latched target's handshake signals are ever looked at.
  assign w_rdy_pad    = NP'(APB_PREADY);
  assign w_slverr_pad = NP'(APB_PSLVERR);
  assign w_ready      = w_rdy_pad[r_idx];
  assign w_slverr     = w_slverr_pad[r_idx];
  assign w_prdata     = APB_PRDATA[r_idx*OBI_DW +: OBI_DW];

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CW'(TIMEOUT_CYCLES));

  assign obi_gnt = obi_req && (r_state == S_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_psel      <= '0;
      r_penable   <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_rvalid    <= 1'b0;
      r_err       <= 1'b0;
      r_err_pulse <= 1'b0;
      r_rdata     <= '0;
      r_rid       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (obi_gnt) begin
            r_rid <= obi_aid;
            if (w_hit) begin
              r_state  <= S_SETUP;
              r_idx    <= w_idx;
              r_psel   <= w_onehot;
              r_paddr  <= obi_addr;
              r_pwrite <= obi_we;
              r_pwdata <= obi_wdata;
              r_pstrb  <= obi_we ? obi_be : '0;
            end else begin
              r_state     <= S_RESP;
              r_rvalid    <= 1'b1;
              r_err       <= 1'b1;
              r_err_pulse <= 1'b1;
              r_rdata     <= '0;
            end
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= r_psel;
          r_cnt     <= '0;
        end
        S_ACCESS: begin
          r_cnt <= w_cnt_inc;
          // PREADY is tested first so a response on the limit cycle completes normally.
          if (w_ready) begin
            r_state     <= S_RESP;
            r_psel      <= '0;
            r_penable   <= '0;
            r_rvalid    <= 1'b1;
            r_rdata     <= r_pwrite ? '0 : w_prdata;
            r_err       <= w_slverr;
            r_err_pulse <= w_slverr;
          end else if (w_timeout) begin
            r_state     <= S_RESP;
            r_psel      <= '0;
            r_penable   <= '0;
            r_rvalid    <= 1'b1;
            r_rdata     <= '0;
            r_err       <= 1'b1;
            r_err_pulse <= 1'b1;
          end
        end
        S_RESP: begin
          r_err_pulse <= 1'b0;
          if (obi_rready) begin
            r_state  <= S_IDLE;
            r_rvalid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign obi_rvalid  = r_rvalid;
  assign obi_rdata   = r_rdata;
  assign obi_rid     = r_rid;
  assign obi_err     = r_err;
  assign err_pulse   = r_err_pulse;
  assign APB_PSEL    = r_psel;
  assign APB_PENABLE = r_penable;
  assign APB_PADDR   = r_paddr;
  assign APB_PWRITE  = r_pwrite;
  assign APB_PWDATA  = r_pwdata;
  assign APB_PSTRB   = r_pstrb;

endmodule

// File: tb/tb_obi_apb_bridge_n.sv
// Scoreboard bench for obi_apb_bridge_n: responses are checked against a queue of
// expectations pushed at each OBI handshake; APB timing is checked per transfer.
module tb_obi_apb_bridge_n;

  localparam int NT = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               obi_req = 1'b0;
  logic               obi_gnt;
  logic [AW-1:0]      obi_addr = '0;
  logic               obi_we = 1'b0;
  logic [DW/8-1:0]    obi_be = '0;
  logic [DW-1:0]      obi_wdata = '0;
  logic [0:0]         obi_aid = '0;
  logic               obi_rvalid;
  logic               obi_rready = 1'b1;
  logic [DW-1:0]      obi_rdata;
  logic [0:0]         obi_rid;
  logic               obi_err;
  logic [NT-1:0]      ss_ctrl_icn = '1;
  logic               err_pulse;
  logic [NT-1:0]      APB_PSEL;
  logic [NT-1:0]      APB_PENABLE;
  logic [AW-1:0]      APB_PADDR;
  logic               APB_PWRITE;
  logic [DW-1:0]      APB_PWDATA;
  logic [DW/8-1:0]    APB_PSTRB;
  logic [NT*DW-1:0]   APB_PRDATA;
  logic [NT-1:0]      APB_PREADY;
  logic [NT-1:0]      APB_PSLVERR;

  always #5 clk = ~clk;

  obi_apb_bridge_n #(
    .NUM_TARGETS(NT), .OBI_AW(AW), .OBI_DW(DW), .OBI_IDW(1),
    .ADDR_BASE(32'h0103_0000), .SS_SIZE('h100), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .obi_req(obi_req), .obi_gnt(obi_gnt), .obi_addr(obi_addr), .obi_we(obi_we),
    .obi_be(obi_be), .obi_wdata(obi_wdata), .obi_aid(obi_aid),
    .obi_rvalid(obi_rvalid), .obi_rready(obi_rready), .obi_rdata(obi_rdata),
    .obi_rid(obi_rid), .obi_err(obi_err), .ss_ctrl_icn(ss_ctrl_icn), .err_pulse(err_pulse),
    .APB_PSEL(APB_PSEL), .APB_PENABLE(APB_PENABLE), .APB_PADDR(APB_PADDR),
    .APB_PWRITE(APB_PWRITE), .APB_PWDATA(APB_PWDATA), .APB_PSTRB(APB_PSTRB),
    .APB_PRDATA(APB_PRDATA), .APB_PREADY(APB_PREADY), .APB_PSLVERR(APB_PSLVERR)
  );

  // APB target model: the selected target answers after wait_n ACCESS cycles;
  // unselected targets drive PREADY/PSLVERR high as noise the bridge must ignore.
  logic [31:0]   tdata [NT];
  int            wait_n = 0;
  logic          hang = 1'b0;
  logic [NT-1:0] slverr_cfg = '0;
  int            acc_cnt = 0;

  always @(posedge clk) acc_cnt <= (|APB_PENABLE) ? acc_cnt + 1 : 0;

  always_comb begin
    APB_PREADY  = '0;
    APB_PSLVERR = '0;
    APB_PRDATA  = '0;
    for (int i = 0; i < NT; i++) begin
      APB_PREADY[i]          = APB_PENABLE[i] ? (!hang && acc_cnt == wait_n) : 1'b1;
      APB_PSLVERR[i]         = APB_PENABLE[i] ? slverr_cfg[i] : 1'b1;
      APB_PRDATA[i*DW +: DW] = tdata[i];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        rid;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t mon_e;

  always @(negedge clk) begin
    if (!reset && obi_rvalid && obi_rready) begin
      if (sb_q.size() == 0) check("unexpected_rsp", 1, 0);
      else begin
        mon_e = sb_q.pop_front();
        check("rsp_rdata", obi_rdata, mon_e.rdata);
        check("rsp_err", obi_err, mon_e.err);
        check("rsp_rid", obi_rid, mon_e.rid);
      end
    end
  end

  int          g_wait;
  int          lat, pen_cyc, ep_cyc, psel_cyc;
  logic [3:0]  psel_seen, psel_at_rsp, pstrb_seen;
  logic [31:0] paddr_seen, pwdata_seen;
  logic        pwrite_seen;

  task automatic start_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input logic id,
                           input logic [31:0] er, input logic ee);
    @(posedge clk); #1;
    obi_req = 1'b1; obi_addr = a; obi_we = we; obi_be = be; obi_wdata = wd; obi_aid = id;
    g_wait = 0;
    @(negedge clk);
    while (!obi_gnt && g_wait < 20) begin
      g_wait++;
      @(negedge clk);
    end
    if (!obi_gnt) begin
      check("gnt_wait", 0, 1);
      obi_req = 1'b0;
      return;
    end
    sb_q.push_back('{rdata: er, err: ee, rid: id});
    @(posedge clk); #1;
    obi_req = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the handshake edge; runs one cycle past rvalid.
  task automatic wait_rsp();
    lat = 0; pen_cyc = 0; ep_cyc = 0; psel_cyc = 0;
    psel_seen = '0; psel_at_rsp = '0; pstrb_seen = '0; paddr_seen = '0;
    pwdata_seen = '0; pwrite_seen = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if ((|APB_PSEL) && psel_seen == '0) begin
        psel_seen = APB_PSEL; psel_cyc = c; paddr_seen = APB_PADDR;
        pstrb_seen = APB_PSTRB; pwdata_seen = APB_PWDATA; pwrite_seen = APB_PWRITE;
      end
      if (|APB_PENABLE) pen_cyc++;
      if (err_pulse) ep_cyc++;
      if (obi_rvalid && lat == 0) begin
        lat = c;
        psel_at_rsp = APB_PSEL | APB_PENABLE;
      end
      if (lat != 0 && c > lat) break;
    end
    if (lat == 0) check("rsp_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    check("watchdog", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    tdata[0] = 32'h0BAD_0000;
    tdata[1] = 32'hA5A5_0001;
    tdata[2] = 32'hDEAD_BEEF;
    tdata[3] = 32'h3333_CAFE;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_psel", APB_PSEL, 0);
    check("rst_penable", APB_PENABLE, 0);
    check("rst_paddr", APB_PADDR, 0);
    check("rst_pwdata", APB_PWDATA, 0);
    check("rst_pstrb", APB_PSTRB, 0);
    check("rst_pwrite", APB_PWRITE, 0);
    check("rst_rvalid", obi_rvalid, 0);
    check("rst_err", obi_err, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_rdata", obi_rdata, 0);
    check("rst_rid", obi_rid, 0);
    reset = 1'b0;

    // Read slot 2, no wait states
    start_req(32'h0103_0204, 1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    wait_rsp();
    check("rd_psel", psel_seen, 4'b0100);
    check("rd_psel_cyc", psel_cyc, 1);
    check("rd_paddr", paddr_seen, 32'h0103_0204);
    check("rd_pstrb", pstrb_seen, 4'b0000);
    check("rd_pen_cyc", pen_cyc, 1);
    check("rd_lat", lat, 3);
    check("rd_sel_dropped", psel_at_rsp, 0);

    // Write slot 0, three wait states
    wait_n = 3;
    start_req(32'h0103_0010, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    wait_rsp();
    check("wr_psel", psel_seen, 4'b0001);
    check("wr_pstrb", pstrb_seen, 4'b0011);
    check("wr_pwdata", pwdata_seen, 32'h1234_5678);
    check("wr_pwrite", pwrite_seen, 1'b1);
    check("wr_pen_cyc", pen_cyc, 4);
    check("wr_lat", lat, 6);
    check("wr_paddr_hold", APB_PADDR, 32'h0103_0010);
    check("wr_psel_idle", APB_PSEL, 0);
    wait_n = 0;

    // Out-of-window, disabled slot, and below-base misses
    start_req(32'h0103_0400, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1);
    wait_rsp();
    check("miss_lat", lat, 1);
    check("miss_pulse", ep_cyc, 1);
    check("miss_psel", psel_seen, 0);
    ss_ctrl_icn = 4'b1101;
    start_req(32'h0103_0100, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1);
    wait_rsp();
    check("dis_lat", lat, 1);
    check("dis_pulse", ep_cyc, 1);
    check("dis_psel", psel_seen, 0);
    ss_ctrl_icn = 4'b1111;
    start_req(32'h0102_FFFC, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1);
    wait_rsp();
    check("below_lat", lat, 1);
    check("below_psel", psel_seen, 0);

    // Timeout with PREADY never asserted
    hang = 1'b1;
    start_req(32'h0103_0104, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1);
    wait_rsp();
    check("to_psel", psel_seen, 4'b0010);
    check("to_pen_cyc", pen_cyc, TO);
    check("to_lat", lat, TO + 2);
    check("to_pulse", ep_cyc, 1);
    check("to_sel_dropped", psel_at_rsp, 0);
    hang = 1'b0;

    // PREADY on the limit cycle wins over the timeout
    wait_n = TO - 1;
    start_req(32'h0103_0108, 1'b0, 4'hF, 32'h0, 1'b0, 32'hA5A5_0001, 1'b0);
    wait_rsp();
    check("lim_pen_cyc", pen_cyc, TO);
    check("lim_lat", lat, TO + 2);
    check("lim_pulse", ep_cyc, 0);
    wait_n = 0;

    // PSLVERR on slot 3 with response backpressure
    slverr_cfg = 4'b1000;
    obi_rready = 1'b0;
    start_req(32'h0103_03F0, 1'b0, 4'hF, 32'h0, 1'b1, 32'h3333_CAFE, 1'b1);
    g_wait = 0;
    @(negedge clk);
    while (!obi_rvalid && g_wait < 20) begin
      g_wait++;
      @(negedge clk);
    end
    check("bp_rvalid_seen", obi_rvalid, 1);
    check("bp_pulse_first", err_pulse, 1);
    @(posedge clk); #1;
    obi_req = 1'b1; obi_addr = 32'h0103_0400; obi_we = 1'b0; obi_aid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rvalid", obi_rvalid, 1);
      check("bp_rdata", obi_rdata, 32'h3333_CAFE);
      check("bp_err", obi_err, 1);
      check("bp_rid", obi_rid, 1);
      check("bp_gnt", obi_gnt, 0);
      check("bp_pulse", err_pulse, 0);
    end
    @(posedge clk); #1;
    obi_rready = 1'b1;
    @(negedge clk);
    check("bp_gnt_hs", obi_gnt, 0);
    @(negedge clk);
    check("bp_gnt_after", obi_gnt, 1);
    if (obi_gnt) sb_q.push_back('{rdata: 32'h0, err: 1'b1, rid: 1'b0});
    @(posedge clk); #1;
    obi_req = 1'b0;
    wait_rsp();
    check("bp_next_lat", lat, 1);
    slverr_cfg = '0;

    // Reset during ACCESS aborts silently
    hang = 1'b1;
    start_req(32'h0103_0008, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    g_wait = 0;
    @(negedge clk);
    while (!(|APB_PENABLE) && g_wait < 10) begin
      g_wait++;
      @(negedge clk);
    end
    check("mr_in_access", |APB_PENABLE, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("mr_psel", APB_PSEL, 0);
    check("mr_penable", APB_PENABLE, 0);
    check("mr_rvalid", obi_rvalid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mr_no_rsp", obi_rvalid, 0);
    end
    hang = 1'b0;
    start_req(32'h0103_0300, 1'b0, 4'hF, 32'h0, 1'b1, 32'h3333_CAFE, 1'b0);
    check("mr_gnt_wait", g_wait, 0);
    wait_rsp();
    check("mr_lat", lat, 3);
    check("mr_psel_after", psel_seen, 4'b1000);

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obi_apb_bridge_n.md
# obi_apb_bridge_n

Parametrised OBI-to-APB splitter for the peripheral interconnect subsystem. It accepts one OBI initiator and decodes a contiguous window of NUM_TARGETS equal-size slots, each mapped to its own APB target port. It adds three things to the fixed four-port split: a per-target enable mask, an error response for unmapped or disabled slots, and a PREADY timeout. It holds one outstanding transaction and uses a registered APB state machine.

## Interface

Parameters:
- NUM_TARGETS, 4, number of APB target ports (1..16)
- OBI_AW, 32, OBI/APB address width
- OBI_DW, 32, OBI/APB data width (multiple of 8)
- OBI_IDW, 1, OBI transaction ID width
- ADDR_BASE, 32'h0103_0000, start of slot 0; aligned to SS_SIZE
- SS_SIZE, 'h100, bytes per slot; power of two
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before abort; 0 disables the timeout

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous reset, active-high
- obi_req  in  1  OBI request
- obi_gnt  out  1  OBI grant
- obi_addr  in  OBI_AW  byte address
- obi_we  in  1  1 = write
- obi_be  in  OBI_DW/8  byte enables
- obi_wdata  in  OBI_DW  write data
- obi_aid  in  OBI_IDW  request ID
- obi_rvalid  out  1  response valid
- obi_rready  in  1  response accept
- obi_rdata  out  OBI_DW  read data
- obi_rid  out  OBI_IDW  echoed ID
- obi_err  out  1  response error
- ss_ctrl_icn  in  NUM_TARGETS  per-slot enable; bit i = 1 enables slot i
- err_pulse  out  1  one-cycle pulse on every error response
- APB_PSEL  out  NUM_TARGETS  one-hot select
- APB_PENABLE  out  NUM_TARGETS  enable, per target
- APB_PADDR  out  OBI_AW  shared address
- APB_PWRITE  out  1  shared write flag
- APB_PWDATA  out  OBI_DW  shared write data
- APB_PSTRB  out  OBI_DW/8  shared strobes
- APB_PRDATA  in  NUM_TARGETS*OBI_DW  read data; target i occupies slice [i*OBI_DW +: OBI_DW]
- APB_PREADY  in  NUM_TARGETS  ready, per target
- APB_PSLVERR  in  NUM_TARGETS  slave error, per target

## Operation

- FSM states: IDLE, SETUP, ACCESS, RESP.
- Grant: obi_gnt = obi_req && state==IDLE (combinational). At the handshake the block latches addr, we, be, wdata, aid, the decoded index and the hit flag.
- Decode: hit when ADDR_BASE <= addr < ADDR_BASE + NUM_TARGETS*SS_SIZE and ss_ctrl_icn[idx]==1, where idx = (addr-ADDR_BASE)/SS_SIZE. ss_ctrl_icn is sampled only at the handshake cycle.
- IDLE→SETUP on a handshake that hits. IDLE→RESP with err=1 and rdata=0 on a handshake that misses; no APB activity occurs.
- SETUP: PSEL[idx]=1, PENABLE=0. PADDR = full latched address; PWRITE = we; PWDATA = wdata; PSTRB = be on writes and 0 on reads. Next state is always ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE[idx]=1; the timeout counter increments each cycle.
  - On PREADY[idx]: move to RESP. Latch rdata = PRDATA slice if read, else 0. Latch err = PSLVERR[idx].
  - If the counter reaches TIMEOUT_CYCLES without PREADY: move to RESP with err=1 and rdata=0; PSEL/PENABLE drop.
- RESP: obi_rvalid=1 with stable rdata, rid and err. On rready, move to IDLE. A new grant is possible only in the cycle after rvalid&&rready.
- err_pulse: high for the first RESP cycle whenever err=1.
- Shared APB outputs (PADDR, PWRITE, PWDATA, PSTRB) hold their last value outside transfers. PSEL and PENABLE are 0 outside SETUP and ACCESS.

## Timing

- Reset (synchronous, takes effect at the edge): state IDLE; all PSEL/PENABLE 0; PADDR, PWDATA, PSTRB, PWRITE 0; obi_rvalid, obi_err, err_pulse 0; rdata and rid 0; counter 0.
- Reset mid-transfer aborts the transfer with no OBI response. PSEL drops in the cycle after the reset edge.
- Hit latency, with handshake at cycle 0 and PREADY=1 at first ACCESS: SETUP in cycle 1, ACCESS in cycle 2, rvalid in cycle 3. Each wait state adds one cycle.
- Miss latency: rvalid in cycle 1.
- Timeout abort: rvalid follows TIMEOUT_CYCLES ACCESS cycles.
- If PREADY arrives in the same cycle the counter hits the limit, PREADY wins and the response is normal.
- A PREADY or PSLVERR from a non-selected target is ignored.
- The timeout counter width is clog2(TIMEOUT_CYCLES+1) and it saturates.
- Address arithmetic uses OBI_AW-bit unsigned compares, so an address below ADDR_BASE must not wrap into a hit.
- Back-to-back: with rready held high, the next grant is possible 1 cycle after rvalid.

## Test plan

- Read, slot 2 (defaults): addr 0x0103_0204, PRDATA[2]=0xDEAD_BEEF, PREADY on the first ACCESS → PSEL=4'b0100, PADDR=0x0103_0204, rvalid at cycle 3 with rdata 0xDEAD_BEEF, err=0.
- Write, slot 0: be=4'b0011, wdata=0x1234_5678, PREADY delayed by 3 cycles → PSTRB=4'b0011, PENABLE high for 4 cycles, rvalid with err=0 and rdata=0.
- Miss and disabled: addr 0x0103_0400 → rvalid at cycle 1, err=1, err_pulse high for 1 cycle, no PSEL. Addr 0x0103_0100 with ss_ctrl_icn=4'b1101 gives the same result. Addr 0x0102_FFFC also misses.
- Timeout: TIMEOUT_CYCLES=8 and PREADY held at 0 → PSEL/PENABLE drop after 8 ACCESS cycles; err=1, rdata=0. A second variant asserts PREADY on the 8th cycle and requires err=0.
- PSLVERR and backpressure: PSLVERR[3]=1 with rready held low for 5 cycles → rvalid, rid and err=1 stay stable; obi_gnt stays 0 for a new req until the cycle after rready.
- Reset mid-ACCESS: assert reset for 1 cycle while PENABLE=1 → next cycle all PSEL/PENABLE are 0, rvalid is 0, state is IDLE; a following read completes normally.
